// File: rtl/trig_pkg.sv
// Shared types and timestamp arithmetic for the trigger pulse generator.
// Timestamps are {TAI seconds, cycles within the second, fine fraction}.
package trig_pkg;

    localparam int c_TAI_WIDTH    = 40;
    localparam int c_CYCLES_WIDTH = 28;
    localparam int c_FRAC_WIDTH   = 12;

    typedef struct packed {
        logic [c_TAI_WIDTH-1:0]    tai;
        logic [c_CYCLES_WIDTH-1:0] cycles;
        logic [c_FRAC_WIDTH-1:0]   frac;
    } t_trig_timestamp;

    typedef enum logic [1:0] {
        TS_LT,
        TS_EQ,
        TS_GT
    } t_ts_cmp;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PULSE
    } t_pulse_state;

    // Delays at or beyond one second are clamped to the last cycle of the second.
    function automatic t_trig_timestamp f_ts_add_cycles(
        input t_trig_timestamp           ts,
        input logic [c_CYCLES_WIDTH-1:0] delay,
        input logic [31:0]               clk_freq
    );
        t_trig_timestamp r;
        logic [31:0]     d;
        logic [31:0]     sum;
        r = ts;
        d = {4'b0, delay};
        if (d >= clk_freq) begin
            d = clk_freq - 32'd1;
        end
        sum = {4'b0, ts.cycles} + d;
        if (sum >= clk_freq) begin
            r.cycles = c_CYCLES_WIDTH'(sum - clk_freq);
            r.tai    = ts.tai + 40'd1;
        end else begin
            r.cycles = sum[c_CYCLES_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic t_ts_cmp f_ts_compare(
        input t_trig_timestamp           ts,
        input logic [c_TAI_WIDTH-1:0]    now_tai,
        input logic [c_CYCLES_WIDTH-1:0] now_cycles
    );
        logic [c_TAI_WIDTH+c_CYCLES_WIDTH-1:0] a;
        logic [c_TAI_WIDTH+c_CYCLES_WIDTH-1:0] b;
        a = {ts.tai, ts.cycles};
        b = {now_tai, now_cycles};
        if (a < b) begin
            return TS_LT;
        end else if (a == b) begin
            return TS_EQ;
        end
        return TS_GT;
    endfunction

endpackage

// File: rtl/trig_ts_fifo.sv
// Synchronous show-ahead FIFO of pending trigger timestamps.
// dout_o always presents the head entry; pushes while full are ignored.
module trig_ts_fifo
    import trig_pkg::*;
#(
    parameter int g_depth = 16
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  t_trig_timestamp din_i,
    input  logic            pop_i,
    output t_trig_timestamp dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            last_o
);

    localparam int c_AW = (g_depth > 1) ? $clog2(g_depth) : 1;

    t_trig_timestamp mem_q [g_depth];
    logic [c_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]   count;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        count   = wr_ptr_q - rd_ptr_q;
        full_o  = (count == (c_AW+1)'(g_depth));
        empty_o = (wr_ptr_q == rd_ptr_q);
        last_o  = (count == (c_AW+1)'(1));
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        dout_o  = mem_q[rd_ptr_q[c_AW-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (c_AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/trig_pulse_gen.sv
// Trigger output stage: delays incoming timestamps, queues them and fires
// a pulse when WR time reaches each one; counts emitted and missed pulses.
//
// state    | meaning
// ST_IDLE  | queue empty, output low
// ST_WAIT  | comparing queue head against WR time
// ST_PULSE | pulse_o high, width down-counter running
module trig_pulse_gen
    import trig_pkg::*;
#(
    parameter int g_clk_freq    = 125000000,
    parameter int g_queue_depth = 16,
    parameter int g_frac_width  = 12
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic                    tm_time_valid_i,
    input  logic [39:0]             tm_tai_i,
    input  logic [27:0]             tm_cycles_i,
    input  logic                    ts_valid_i,
    output logic                    ts_ready_o,
    input  logic [39:0]             ts_tai_i,
    input  logic [27:0]             ts_cycles_i,
    input  logic [g_frac_width-1:0] ts_frac_i,
    input  logic                    enable_i,
    input  logic [27:0]             delay_c_i,
    input  logic [15:0]             pulse_width_i,
    input  logic                    rst_cnt_i,
    output logic                    pulse_o,
    output logic [g_frac_width-1:0] pulse_frac_o,
    output logic [31:0]             cnt_pulses_o,
    output logic [31:0]             cnt_missed_o
);

    localparam logic [31:0] c_CLK_FREQ = 32'(g_clk_freq);

    logic                    ready_q, ready_d;
    logic                    stg_valid_q, stg_valid_d;
    t_trig_timestamp         stg_ts_q, stg_ts_d;
    t_pulse_state            state_q, state_d;
    logic                    pulse_q, pulse_d;
    logic [g_frac_width-1:0] frac_q, frac_d;
    logic [15:0]             width_cnt_q, width_cnt_d;
    logic [31:0]             cnt_pulses_q, cnt_pulses_d;
    logic [31:0]             cnt_missed_q, cnt_missed_d;

    t_trig_timestamp         ts_in;
    t_trig_timestamp         fifo_head;
    t_ts_cmp                 head_cmp;
    logic                    accept;
    logic                    fifo_push, fifo_pop;
    logic                    fifo_full, fifo_empty, fifo_last;
    logic                    full_drop, miss_late;
    logic [1:0]              miss_inc;
    logic [32:0]             miss_sum;

    always_comb begin
        accept       = ts_valid_i & ready_q;
        ts_in.tai    = ts_tai_i;
        ts_in.cycles = ts_cycles_i;
        ts_in.frac   = c_FRAC_WIDTH'(ts_frac_i);
        ready_d      = 1'b1;
        stg_valid_d  = accept & enable_i;
        stg_ts_d     = accept ? f_ts_add_cycles(ts_in, delay_c_i, c_CLK_FREQ) : stg_ts_q;
        fifo_push    = stg_valid_q & enable_i;
        full_drop    = fifo_push & fifo_full;
        head_cmp     = f_ts_compare(fifo_head, tm_tai_i, tm_cycles_i);
    end

    trig_ts_fifo #(
        .g_depth (g_queue_depth)
    ) u_fifo (
        .clk_i   (clk_sys_i),
        .rst_n_i (rst_n_i),
        .flush_i (~enable_i),
        .push_i  (fifo_push),
        .din_i   (stg_ts_q),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .last_o  (fifo_last)
    );

    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        frac_d      = frac_q;
        width_cnt_d = width_cnt_q;
        fifo_pop    = 1'b0;
        miss_late   = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            pulse_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pulse_d = 1'b0;
                    if (!fifo_empty) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (fifo_empty) begin
                        state_d = ST_IDLE;
                    end else if (tm_time_valid_i) begin
                        case (head_cmp)
                            TS_EQ: begin
                                fifo_pop    = 1'b1;
                                pulse_d     = 1'b1;
                                frac_d      = g_frac_width'(fifo_head.frac);
                                width_cnt_d = (pulse_width_i == 16'd0) ? 16'd0 : pulse_width_i - 16'd1;
                                state_d     = ST_PULSE;
                            end
                            TS_LT: begin
                                fifo_pop  = 1'b1;
                                miss_late = 1'b1;
                                if (fifo_last && !fifo_push) state_d = ST_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PULSE: begin
                    // Pulse runs to completion even if the time base drops out.
                    if (width_cnt_q == 16'd0) begin
                        pulse_d = 1'b0;
                        state_d = fifo_empty ? ST_IDLE : ST_WAIT;
                    end else begin
                        width_cnt_d = width_cnt_q - 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        miss_inc = {1'b0, miss_late} + {1'b0, full_drop};
        miss_sum = {1'b0, cnt_missed_q} + {31'b0, miss_inc};
        if (rst_cnt_i) begin
            cnt_missed_d = '0;
        end else begin
            cnt_missed_d = miss_sum[32] ? '1 : miss_sum[31:0];
        end

        cnt_pulses_d = cnt_pulses_q;
        if (rst_cnt_i) begin
            cnt_pulses_d = '0;
        end else if (pulse_d && !pulse_q && cnt_pulses_q != '1) begin
            cnt_pulses_d = cnt_pulses_q + 32'd1;
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            ready_q      <= 1'b0;
            stg_valid_q  <= 1'b0;
            stg_ts_q     <= '0;
            state_q      <= ST_IDLE;
            pulse_q      <= 1'b0;
            frac_q       <= '0;
            width_cnt_q  <= '0;
            cnt_pulses_q <= '0;
            cnt_missed_q <= '0;
        end else begin
            ready_q      <= ready_d;
            stg_valid_q  <= stg_valid_d;
            stg_ts_q     <= stg_ts_d;
            state_q      <= state_d;
            pulse_q      <= pulse_d;
            frac_q       <= frac_d;
            width_cnt_q  <= width_cnt_d;
            cnt_pulses_q <= cnt_pulses_d;
            cnt_missed_q <= cnt_missed_d;
        end
    end

    assign ts_ready_o   = ready_q;
    assign pulse_o      = pulse_q;
    assign pulse_frac_o = frac_q;
    assign cnt_pulses_o = cnt_pulses_q;
    assign cnt_missed_o = cnt_missed_q;

endmodule
